// File: rtl/ir_sweep_seq.sv
// IR line-sensor sweep sequencer: powers the emitters, converts each channel through
// the A2D interface, stores the results and publishes right-minus-left position error.
module ir_sweep_seq #(
    parameter int NUM_CH    = 6,
    parameter int IR_SETTLE = 4096,
    parameter int TMO       = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    output logic               strt_cnv,
    output logic [2:0]         chnnl,
    input  logic               cnv_cmplt,
    input  logic [11:0]        res,
    output logic               IR_en,
    output logic               busy,
    output logic               sweep_done,
    output logic signed [15:0] err,
    output logic               a2d_tmo,
    input  logic [2:0]         rd_idx,
    output logic [11:0]        rd_res
);

    localparam int SW = $clog2(IR_SETTLE + 1);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(IR_SETTLE - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TMO - 1);
    localparam logic [2:0]    LAST_CH     = 3'(NUM_CH - 1);
    localparam logic [2:0]    HALF_CH     = 3'(NUM_CH / 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] wait_cnt;
    logic [11:0]   cap_res;
    logic [13:0]   left_acc;
    logic [13:0]   right_acc;
    logic [11:0]   bank [NUM_CH];

    assign strt_cnv = (state == S_START);
    assign busy     = (state != S_IDLE);

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            IR_en      <= 1'b0;
            sweep_done <= 1'b0;
            a2d_tmo    <= 1'b0;
            chnnl      <= '0;
            err        <= '0;
            settle_cnt <= '0;
            wait_cnt   <= '0;
            cap_res    <= '0;
            left_acc   <= '0;
            right_acc  <= '0;
            // NOTE: the bank is reset because rd_res exposes it directly; a reset
            // sweep must read back as zeros, not leftover data.
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state      <= S_SETTLE;
                        a2d_tmo    <= 1'b0;
                        settle_cnt <= '0;
                        chnnl      <= '0;
                        IR_en      <= 1'b1;
                        left_acc   <= '0;
                        right_acc  <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= S_START;
                    else settle_cnt <= settle_cnt + 1'b1;
                end
                S_START: state <= S_GAP;
                // cnv_cmplt may still be high from the previous conversion here.
                S_GAP: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnv_cmplt) begin
                        cap_res <= res;
                        state   <= S_CAPTURE;
                    end else if (wait_cnt == TMO_LAST) begin
                        cap_res <= '0;
                        a2d_tmo <= 1'b1;
                        state   <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    bank[chnnl] <= cap_res;
                    if (chnnl < HALF_CH) left_acc  <= left_acc + 14'(cap_res);
                    else                 right_acc <= right_acc + 14'(cap_res);
                    if (chnnl == LAST_CH) begin
                        state <= S_DONE;
                    end else begin
                        chnnl <= chnnl + 1'b1;
                        state <= S_START;
                    end
                end
                S_DONE: begin
                    err        <= 16'(right_acc) - 16'(left_acc);
                    IR_en      <= 1'b0;
                    sweep_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: rd_res gets a default before the conditional so no latch is inferred.
    always_comb begin
        rd_res = '0;
        if (32'(rd_idx) < NUM_CH) rd_res = bank[rd_idx];
    end

endmodule
